// File: rtl/disaggregator.sv
// Wide-to-narrow width converter: pops one FETCH_WIDTH*DATA_WIDTH word, emits FETCH_WIDTH narrow lanes.
// Optional: define DISAGGREGATOR_MSB_FIRST_EN to emit the highest lane first.
module disaggregator #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FETCH_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  output logic                              receiver_last
);

  localparam int unsigned CW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int unsigned WW = FETCH_WIDTH * DATA_WIDTH;

`ifdef DISAGGREGATOR_MSB_FIRST_EN
  localparam logic [CW-1:0] FIRST_LANE = CW'(FETCH_WIDTH - 1);
  localparam logic [CW-1:0] FINAL_LANE = '0;
`else
  localparam logic [CW-1:0] FIRST_LANE = '0;
  localparam logic [CW-1:0] FINAL_LANE = CW'(FETCH_WIDTH - 1);
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q;
  logic [WW-1:0]   hold_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_next;
  logic            busy;

  assign busy          = (state_q == SEND);
  assign receiver_enq  = busy & receiver_full_n;
  assign receiver_last = receiver_enq & (cnt_q == FINAL_LANE);
  assign sender_deq    = ~rst & sender_empty_n & (~busy | receiver_last);
  assign receiver_data = hold_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef DISAGGREGATOR_MSB_FIRST_EN
  assign cnt_next = cnt_q - CW'(1);
`else
  assign cnt_next = cnt_q + CW'(1);
`endif

  // Lane sequencer; a stalled receiver freezes all state so the presented lane stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sender_deq) begin
            hold_q  <= sender_data;
            cnt_q   <= FIRST_LANE;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (receiver_last) begin
            if (sender_deq) begin
              hold_q <= sender_data;
              cnt_q  <= FIRST_LANE;
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end else if (receiver_enq) begin
            cnt_q <= cnt_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Self-checking bench for disaggregator: directed scenarios plus randomized stalls on FETCH_WIDTH=1,2,3.
module tb_disaggregator;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } elem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        empty_n;
  logic        full_n;
  logic [7:0]  base;
  logic [7:0]  sd1;
  logic [15:0] sd2;
  logic [23:0] sd3;
  int          fw;

  logic        deq1, deq2, deq3, enq1, enq2, enq3, last1, last2, last3;
  logic [7:0]  dat1, dat2, dat3;
  logic        o_deq, o_enq, o_last;
  logic [7:0]  o_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int deqs = 0;

  elem_t      q[$];
  logic [7:0] src[$];
  logic [7:0] rx[$];
  logic       rx_last[$];
  int         rx_cyc[$];

  always #5 clk = ~clk;

  assign sd1 = base;
  assign sd2 = {8'(base + 8'd1), base};
  assign sd3 = {8'(base + 8'd2), 8'(base + 8'd1), base};

  assign o_deq  = (fw == 1) ? deq1  : (fw == 3) ? deq3  : deq2;
  assign o_enq  = (fw == 1) ? enq1  : (fw == 3) ? enq3  : enq2;
  assign o_last = (fw == 1) ? last1 : (fw == 3) ? last3 : last2;
  assign o_data = (fw == 1) ? dat1  : (fw == 3) ? dat3  : dat2;

  disaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .sender_data(sd1), .sender_empty_n(empty_n), .sender_deq(deq1),
    .receiver_data(dat1), .receiver_full_n(full_n), .receiver_enq(enq1), .receiver_last(last1));

  disaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .sender_data(sd2), .sender_empty_n(empty_n), .sender_deq(deq2),
    .receiver_data(dat2), .receiver_full_n(full_n), .receiver_enq(enq2), .receiver_last(last2));

  disaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .sender_data(sd3), .sender_empty_n(empty_n), .sender_deq(deq3),
    .receiver_data(dat3), .receiver_full_n(full_n), .receiver_enq(enq3), .receiver_last(last3));

  // Element i of a stream whose word w holds values w*fw+lane in lane order.
  function automatic logic [7:0] exp_gen(input int i, input int width);
    int p;
    int w;
    int lane;
    p = i % width;
    w = i / width;
`ifdef DISAGGREGATOR_MSB_FIRST_EN
    lane = width - 1 - p;
`else
    lane = p;
`endif
    return 8'(w * width + lane);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive sender/receiver, check outputs against the model at negedge, advance model at posedge.
  task automatic step(input logic e_en, input logic f);
    logic xe;
    logic xd;
    logic [7:0] b;
    empty_n = e_en && (src.size() != 0);
    b = (src.size() != 0) ? src[0] : 8'h00;
    base = b;
    full_n = f;
    @(negedge clk);
    xe = (q.size() != 0) && f;
    xd = empty_n && ((q.size() == 0) || (xe && q.size() == 1));
    chk("receiver_enq", 32'(o_enq), 32'(xe));
    chk("sender_deq", 32'(o_deq), 32'(xd));
    if (q.size() != 0) begin
      chk("receiver_data", 32'(o_data), 32'(q[0].d));
      chk("receiver_last", 32'(o_last), 32'(xe && q[0].last));
    end else begin
      chk("receiver_last_idle", 32'(o_last), 32'd0);
    end
    if (xe) begin
      rx.push_back(o_data);
      rx_last.push_back(o_last);
      rx_cyc.push_back(cyc);
    end
    if (o_deq) deqs++;
    @(posedge clk);
    if (xe) void'(q.pop_front());
    if (xd) begin
      for (int k = 0; k < fw; k++) begin
        elem_t e;
`ifdef DISAGGREGATOR_MSB_FIRST_EN
        e.d = 8'(b + 8'(fw - 1 - k));
`else
        e.d = 8'(b + 8'(k));
`endif
        e.last = (k == fw - 1);
        q.push_back(e);
      end
      void'(src.pop_front());
    end
    cyc++;
    #1;
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (rx.size() < n && c < budget) begin
      step(1'b1, 1'b1);
      c++;
    end
    chk("timeout_rx_count", 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    empty_n = 1'b1;
    full_n = 1'b1;
    base = 8'h5a;
    @(posedge clk);
    #1;
    chk("rst_sender_deq", 32'(o_deq), 32'd0);
    chk("rst_receiver_enq", 32'(o_enq), 32'd0);
    chk("rst_receiver_last", 32'(o_last), 32'd0);
    chk("rst_receiver_data", 32'(o_data), 32'd0);
    rst = 1'b0;
    empty_n = 1'b0;
    q.delete();
    src.delete();
    rx.delete();
    rx_last.delete();
    rx_cyc.delete();
    deqs = 0;
  endtask

  initial begin
    int d;
    rst = 1'b1;
    empty_n = 1'b0;
    full_n = 1'b0;
    base = 8'h00;
    fw = 2;
    #3;

    // Back-to-back stream, receiver always ready.
    reset_dut();
    src = '{8'h00, 8'h02, 8'h04};
    run_until(6, 20);
    for (int i = 0; i < 6; i++) begin
      chk("b2b_data", 32'(rx[i]), 32'(exp_gen(i, 2)));
      chk("b2b_last", 32'(rx_last[i]), 32'(i % 2 == 1));
    end
    chk("b2b_consecutive", 32'(rx_cyc[5] - rx_cyc[0]), 32'd5);
    chk("b2b_deq_count", 32'(deqs), 32'd3);

    // Receiver stall after element 0.
    reset_dut();
    src = '{8'h00, 8'h02, 8'h04};
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("stall_data_held", 32'(o_data), 32'(exp_gen(1, 2)));
    end
    run_until(6, 20);
    chk("stall_rx_count", 32'(rx.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("stall_data", 32'(rx[i]), 32'(exp_gen(i, 2)));

    // Sender runs dry, then a late word.
    reset_dut();
    src = '{8'h00};
    run_until(2, 10);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("idle_enq", 32'(o_enq), 32'd0);
    chk("idle_rx_count", 32'(rx.size()), 32'd2);
    src.push_back(8'h02);
    d = cyc;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("late_lane0_data", 32'(rx[2]), 32'(exp_gen(2, 2)));
    chk("late_lane0_latency", 32'(rx_cyc[2]), 32'(d + 1));

    // Reset mid-word discards the held word.
    reset_dut();
    src = '{8'h02, 8'h04};
    run_until(1, 10);
    empty_n = 1'b1;
    full_n = 1'b1;
    base = src[0];
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sender_deq", 32'(o_deq), 32'd0);
    chk("midrst_receiver_enq", 32'(o_enq), 32'd0);
    chk("midrst_receiver_last", 32'(o_last), 32'd0);
    chk("midrst_receiver_data", 32'(o_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    run_until(3, 10);
    chk("midrst_first", 32'(rx[0]), 32'(exp_gen(2, 2)));
    chk("midrst_next0", 32'(rx[1]), 32'(exp_gen(4, 2)));
    chk("midrst_next1", 32'(rx[2]), 32'(exp_gen(5, 2)));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("midrst_rx_count", 32'(rx.size()), 32'd3);

    // Random two-sided stalls across widths 1, 2 and 3.
    for (int w = 1; w <= 3; w++) begin
      fw = w;
      reset_dut();
      for (int k = 0; k < 200; k++) src.push_back(8'(k * w));
      for (int c = 0; c < 600; c++) step(($urandom % 4) != 0, ($urandom % 3) != 0);
      chk("rand_progress", 32'(rx.size() >= 100), 32'd1);
      for (int i = 0; i < rx.size(); i++) begin
        chk("rand_data", 32'(rx[i]), 32'(exp_gen(i, w)));
        chk("rand_last", 32'(rx_last[i]), 32'(i % w == w - 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
